// File: rtl/reg_piso_tx_ers_pkg.sv
// Shared definitions for the LSB-first PISO transmitter: FSM state encoding
// and the counter-width helper.
package reg_piso_tx_ers_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bits needed to index 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_piso_tx_ers_cnt_mod_n.sv
// Modulo-N up counter with synchronous clear; tc flags the terminal count N-1.
// Incrementing at the terminal count wraps to zero.
module cnt_mod_n
  import reg_piso_tx_ers_pkg::*;
#(
  parameter int N = 4,
  localparam int W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         tc
);

  assign tc = (q == W'(N - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= tc ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/reg_piso_tx_ers.sv
// Parallel-in/serial-out transmitter: loads a WIDTH-bit word by valid/ready and
// shifts it out LSB first, one bit per enabled clock, with gapless reload.
module reg_piso_tx_ers
  import reg_piso_tx_ers_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0,
  localparam int  CW         = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] dato_in,
  input  logic             valid_in,
  output logic             ready,
  output logic             salida,
  output logic             salida_valid,
  output logic             busy,
  output logic             done,
  output state_t           state_dbg,
  output logic [CW-1:0]    bit_idx
);

  // Handshake: a word transfers in any cycle where valid_in & ready; valid_in
  // without ready is ignored and dato_in is only sampled in the transfer cycle.
  // ready is combinational so the final bit of a word can overlap the next load.

  state_t     state, state_next;
  logic [WIDTH-1:0] q;
  logic       accept, last, cnt_tc;

  cnt_mod_n #(.N(WIDTH)) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .inc   (enable & busy),
    .q     (bit_idx),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    busy         = (state == ST_SHIFT);
    salida_valid = busy;
    salida       = busy ? q[0] : IDLE_LEVEL;
    last         = busy & enable & cnt_tc;
    ready        = ~busy | last;
    accept       = valid_in & ready;
    unique case (state)
      ST_IDLE:  if (accept) state_next = ST_SHIFT;
      ST_SHIFT: if (last && !accept) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // A load wins over shifting; clearing on the final bit keeps q at zero while idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q    <= '0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        q <= dato_in;
      end else if (last) begin
        q <= '0;
      end else if (busy && enable) begin
        q <= {IDLE_LEVEL, q[WIDTH-1:1]};
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_reg_piso_tx_ers.sv
// Directed bench for reg_piso_tx_ers (WIDTH=4): per-cycle vector table plus a
// serial-in loopback sink over random words.
module tb_reg_piso_tx_ers;
  import reg_piso_tx_ers_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] dato_in = '0;
  logic       valid_in = 1'b0;
  logic       ready, salida, salida_valid, busy, done;
  state_t     state_dbg;
  logic [1:0] bit_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_piso_tx_ers #(.WIDTH(4), .IDLE_LEVEL(1'b0)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .dato_in      (dato_in),
    .valid_in     (valid_in),
    .ready        (ready),
    .salida       (salida),
    .salida_valid (salida_valid),
    .busy         (busy),
    .done         (done),
    .state_dbg    (state_dbg),
    .bit_idx      (bit_idx)
  );

  // Loopback sink: LSB-first serial-in register
  logic [3:0] sink_sr = '0;
  always @(posedge clk) begin
    if (salida_valid && enable) sink_sr <= {salida, sink_sr[3:1]};
  end

  typedef struct {
    logic       rst, en, vld;
    logic [3:0] d;
    logic       chk;
    logic       e_rdy, e_s, e_sv, e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rst, en, vld, input logic [3:0] d,
                             input logic chk, e_rdy, e_s, e_sv, e_done);
    vec_t r;
    r.rst = rst; r.en = en; r.vld = vld; r.d = d; r.chk = chk;
    r.e_rdy = e_rdy; r.e_s = e_s; r.e_sv = e_sv; r.e_done = e_done;
    return r;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset, then basic word 1011
    vecs.push_back(v(0,0,0,4'h0, 0, 0,0,0,0));
    vecs.push_back(v(0,0,0,4'h0, 0, 0,0,0,0));
    vecs.push_back(v(1,1,1,4'b1011, 1, 1,0,0,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 0,1,1,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 0,1,1,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 0,0,1,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 1,1,1,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 1,0,0,1));
    vecs.push_back(v(1,1,0,4'h0, 1, 1,0,0,0));
    // enable gaps on 0110, accepted while enable=0
    vecs.push_back(v(1,0,1,4'b0110, 1, 1,0,0,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 0,0,1,0));
    vecs.push_back(v(1,0,0,4'h0, 1, 0,1,1,0));
    vecs.push_back(v(1,0,0,4'h0, 1, 0,1,1,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 0,1,1,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 0,1,1,0));
    vecs.push_back(v(1,0,0,4'h0, 1, 0,0,1,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 1,0,1,0));
    vecs.push_back(v(1,0,0,4'h0, 1, 1,0,0,1));
    // back-to-back 1011 then 0110
    vecs.push_back(v(1,1,1,4'b1011, 1, 1,0,0,0));
    vecs.push_back(v(1,1,1,4'b0110, 1, 0,1,1,0));
    vecs.push_back(v(1,1,1,4'b0110, 1, 0,1,1,0));
    vecs.push_back(v(1,1,1,4'b0110, 1, 0,0,1,0));
    vecs.push_back(v(1,1,1,4'b0110, 1, 1,1,1,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 0,0,1,1));
    vecs.push_back(v(1,1,0,4'h0, 1, 0,1,1,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 0,1,1,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 1,0,1,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 1,0,0,1));
    // reset after two bits of 1111
    vecs.push_back(v(1,1,1,4'b1111, 1, 1,0,0,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 0,1,1,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 0,1,1,0));
    vecs.push_back(v(0,1,0,4'h0, 1, 0,1,1,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 1,0,0,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 1,0,0,0));
    // valid_in pulsed with 0000 while busy sending 1001
    vecs.push_back(v(1,1,1,4'b1001, 1, 1,0,0,0));
    vecs.push_back(v(1,1,1,4'b0000, 1, 0,1,1,0));
    vecs.push_back(v(1,1,1,4'b0000, 1, 0,0,1,0));
    vecs.push_back(v(1,1,1,4'b0000, 1, 0,0,1,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 1,1,1,0));
    vecs.push_back(v(1,1,0,4'h0, 1, 1,0,0,1));
    vecs.push_back(v(1,1,0,4'h0, 1, 1,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; enable = vecs[i].en;
      valid_in = vecs[i].vld; dato_in = vecs[i].d;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("row%0d_ready", i), {3'b0, ready}, {3'b0, vecs[i].e_rdy});
        check($sformatf("row%0d_salida", i), {3'b0, salida}, {3'b0, vecs[i].e_s});
        check($sformatf("row%0d_valid", i), {3'b0, salida_valid}, {3'b0, vecs[i].e_sv});
        check($sformatf("row%0d_busy", i), {3'b0, busy}, {3'b0, vecs[i].e_sv});
        check($sformatf("row%0d_done", i), {3'b0, done}, {3'b0, vecs[i].e_done});
      end
      tick();
    end

    // loopback over random words with random enable gaps
    valid_in = 1'b0; enable = 1'b0;
    tick();
    for (int w = 0; w < 16; w++) begin
      logic [3:0] word;
      int         budget;
      int         dones;
      word = 4'($urandom_range(0, 15));
      check($sformatf("lb%0d_ready", w), {3'b0, ready}, 4'h1);
      valid_in = 1'b1; dato_in = word; enable = 1'($urandom_range(0, 1));
      tick();
      valid_in = 1'b0; dato_in = 4'h0;
      budget = 0; dones = 0;
      while (dones == 0 && budget < 64) begin
        enable = 1'($urandom_range(0, 1));
        tick();
        if (done) dones++;
        budget++;
      end
      if (dones == 0) begin
        checks++; failures++;
        $display("FAIL lb%0d_timeout actual=no_done required=done_within_64", w);
      end else begin
        check($sformatf("lb%0d_word", w), sink_sr, word);
      end
      enable = 1'b0;
      tick();
      check($sformatf("lb%0d_done_once", w), {3'b0, done}, 4'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
